// File: rtl/rv_pkg.sv
// Shared constants and types for the RV32IC integer datapath.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0] word_t;

  localparam reg_idx_t ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_file_2r1w_word.sv
// Single-word load register: clears asynchronously on reset and captures data when load is high.
module reg_file_2r1w_word #(
  parameter int W = 32
) (
  input  logic         reset,
  input  logic         clock,
  input  logic [W-1:0] data,
  input  logic         load,
  output logic [W-1:0] out
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out <= '0;
    end else if (load) begin
      out <= data;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Integer register file: x0 is hardwired to zero, with one write port, two combinational reads and a write counter.
// Optional macro RF_BYPASS_EN adds write-through forwarding from the write port to both read ports.
module reg_file_2r1w
  import rv_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic       wr_en,
  input  reg_idx_t   wr_addr,
  input  word_t      wr_data,
  input  reg_idx_t   rd_addr1,
  output word_t      rd_data1,
  input  reg_idx_t   rd_addr2,
  output word_t      rd_data2,
  output logic [7:0] wr_cnt
);

  word_t regs [NREG];
  logic  wr_commit;

  assign regs[0]   = '0;
  assign wr_commit = wr_en && (wr_addr != ZERO_REG);

  for (genvar i = 1; i < NREG; i++) begin : g_word
    reg_file_2r1w_word #(.W(XLEN)) u_word (
      .reset (res),
      .clock (clk),
      .data  (wr_data),
      .load  (wr_en && (wr_addr == reg_idx_t'(i))),
      .out   (regs[i])
    );
  end

`ifdef RF_BYPASS_EN
  // x0 never matches because wr_commit excludes it; stored words are already zero in reset.
  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_data2 = regs[rd_addr2];
    if (!res && wr_commit && (rd_addr1 == wr_addr)) rd_data1 = wr_data;
    if (!res && wr_commit && (rd_addr2 == wr_addr)) rd_data2 = wr_data;
  end
`else
  assign rd_data1 = regs[rd_addr1];
  assign rd_data2 = regs[rd_addr2];
`endif

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_cnt <= '0;
    end else if (wr_commit) begin
      wr_cnt <= wr_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Randomized self-checking bench for reg_file_2r1w against an array-based register model.
module tb_reg_file_2r1w;
  import rv_pkg::*;

  logic       clk = 1'b0;
  logic       res;
  logic       wr_en;
  reg_idx_t   wr_addr;
  word_t      wr_data;
  reg_idx_t   rd_addr1;
  word_t      rd_data1;
  reg_idx_t   rd_addr2;
  word_t      rd_data2;
  logic [7:0] wr_cnt;

  int tests = 0;
  int fails = 0;

  word_t      mdl [32];
  logic [7:0] mdl_cnt;

  reg_file_2r1w dut (
    .clk      (clk),
    .res      (res),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1),
    .rd_addr2 (rd_addr2),
    .rd_data2 (rd_data2),
    .wr_cnt   (wr_cnt)
  );

  always #5 clk = ~clk;

  function automatic word_t mdl_read(input int a);
`ifdef RF_BYPASS_EN
    if (!res && wr_en && wr_addr != 0 && int'(wr_addr) == a) return wr_data;
`endif
    return (a == 0) ? 32'd0 : mdl[a];
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    mdl_cnt = 8'd0;
  endtask

  // Advance one edge and apply the architectural write rule to the model.
  task automatic step();
    @(posedge clk);
    if (!res && wr_en && wr_addr != 0) begin
      mdl[wr_addr] = wr_data;
      mdl_cnt = mdl_cnt + 8'd1;
    end
    if (res) mdl_clear();
    #1;
  endtask

  task automatic write(input int a, input word_t d);
    wr_en = 1'b1; wr_addr = reg_idx_t'(a); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;
    mdl_clear();
    repeat (2) step();
    for (int a = 0; a < 32; a += 7) begin
      rd_addr1 = reg_idx_t'(a); rd_addr2 = reg_idx_t'(31 - a); #1;
      tests++;
      if (rd_data1 !== 32'd0 || rd_data2 !== 32'd0) begin
        fails++;
        $display("FAIL reset_read a=%0d got %h/%h want 0", a, rd_data1, rd_data2);
      end
    end
    tests++;
    if (wr_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", wr_cnt); end
    res = 1'b0;
    step();
    write(5, 32'hDEADBEEF);
    rd_addr1 = 5; #1;
    tests++;
    if (rd_data1 !== 32'hDEADBEEF) begin fails++; $display("FAIL preload_x5 got %h want deadbeef", rd_data1); end
    #2 res = 1'b1; #1;
    tests++;
    if (rd_data1 !== 32'd0 || wr_cnt !== 8'd0) begin
      fails++;
      $display("FAIL async_reset got %h cnt %0d want 0 cnt 0", rd_data1, wr_cnt);
    end
    step();
    res = 1'b0;
  endtask

  task automatic test_x0();
    int c0;
    write(3, 32'h1234);
    c0 = mdl_cnt;
    write(0, 32'hFFFFFFFF);
    rd_addr1 = 0; rd_addr2 = 3; #1;
    tests++;
    if (rd_data1 !== 32'd0 || wr_cnt !== 8'(c0) || rd_data2 !== 32'h1234) begin
      fails++;
      $display("FAIL x0_protect got %h cnt %0d x3 %h want 0 cnt %0d x3 1234", rd_data1, wr_cnt, rd_data2, c0);
    end
  endtask

  task automatic test_normal();
    res = 1'b1; step(); res = 1'b0;
    write(1, 32'd3);
    write(31, 32'h80000000);
    rd_addr1 = 1; rd_addr2 = 31; #1;
    tests++;
    if (rd_data1 !== 32'd3 || rd_data2 !== 32'h80000000 || wr_cnt !== 8'd2) begin
      fails++;
      $display("FAIL normal_rw got %h %h cnt %0d want 3 80000000 cnt 2", rd_data1, rd_data2, wr_cnt);
    end
    rd_addr1 = 31; rd_addr2 = 31; #1;
    tests++;
    if (rd_data1 !== 32'h80000000 || rd_data2 !== 32'h80000000) begin
      fails++;
      $display("FAIL same_addr got %h %h want 80000000", rd_data1, rd_data2);
    end
  endtask

  task automatic test_collision();
    word_t pre;
    write(7, 32'd10);
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'd20; rd_addr1 = 7; #1;
`ifdef RF_BYPASS_EN
    pre = 32'd20;
`else
    pre = 32'd10;
`endif
    tests++;
    if (rd_data1 !== pre) begin fails++; $display("FAIL collide_before got %0d want %0d", rd_data1, pre); end
    step();
    wr_en = 1'b0; #1;
    tests++;
    if (rd_data1 !== 32'd20) begin fails++; $display("FAIL collide_after got %0d want 20", rd_data1); end
  endtask

  task automatic test_reset_vs_write();
    write(4, 32'd55);
    res = 1'b1; wr_en = 1'b1; wr_addr = 4; wr_data = 32'd9; rd_addr1 = 4;
    step();
    wr_en = 1'b0; res = 1'b0; #1;
    tests++;
    if (rd_data1 !== 32'd0 || wr_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_vs_write got %0d cnt %0d want 0 cnt 0", rd_data1, wr_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wr_en    = ($urandom_range(3) != 0);
      wr_addr  = reg_idx_t'($urandom_range(31));
      wr_data  = $urandom;
      rd_addr1 = ($urandom_range(3) == 0) ? wr_addr : reg_idx_t'($urandom_range(31));
      rd_addr2 = reg_idx_t'($urandom_range(31));
      #1;
      tests++;
      if (rd_data1 !== mdl_read(rd_addr1) || rd_data2 !== mdl_read(rd_addr2)) begin
        fails++;
        $display("FAIL rand_read n=%0d a=%0d/%0d got %h/%h want %h/%h", n, rd_addr1, rd_addr2,
                 rd_data1, rd_data2, mdl_read(rd_addr1), mdl_read(rd_addr2));
      end
      step();
      tests++;
      if (wr_cnt !== mdl_cnt) begin fails++; $display("FAIL rand_cnt n=%0d got %0d want %0d", n, wr_cnt, mdl_cnt); end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_wrap();
    int a;
    word_t d;
    res = 1'b1; step(); res = 1'b0;
    a = 1; d = 0;
    for (int n = 0; n < 256; n++) begin
      a = $urandom_range(31, 1);
      d = $urandom;
      write(a, d);
    end
    rd_addr1 = reg_idx_t'(a); #1;
    tests++;
    if (wr_cnt !== 8'd0 || rd_data1 !== d) begin
      fails++;
      $display("FAIL cnt_wrap got cnt %0d x%0d=%h want cnt 0 %h", wr_cnt, a, rd_data1, d);
    end
    write(2, 32'd1);
    tests++;
    if (wr_cnt !== 8'd1) begin fails++; $display("FAIL cnt_after_wrap got %0d want 1", wr_cnt); end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_normal();
    test_collision();
    test_reset_vs_write();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
